mult_array_scan_reader: RTL

- Drives the operand and address ports of the 32x34 GNN multiplier array wrapper and reads its product port back.
- Latches one feature vector and one weight vector on start, then waits for the multiplier pipeline to settle.
- Scans a programmable row x column window in row-major order and streams each product out over a valid/ready interface.
- Acts as the read-side controller for the multiplier array in the graph_conv datapath and benches.

---
 rtl/mult_array_scan_reader.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mult_array_scan_reader.sv
// Read-side controller for the 32x34 multiplier array: latches operands, waits for
// the array pipeline to settle, then streams a row-major product window. Optional MULT_SCAN_SUM_EN.
module mult_array_scan_reader #(
  parameter int LATENCY = 2,
  parameter int ROWS    = 32,
  parameter int COLS    = 34
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [8*ROWS-1:0]   feature_in,
  input  logic [8*COLS-1:0]   weight_in,
  input  logic [5:0]          n_rows,
  input  logic [5:0]          n_cols,
  output logic [8*ROWS-1:0]   feature,
  output logic [8*COLS-1:0]   weight,
  output logic [5:0]          addr_i,
  output logic [5:0]          addr_j,
  input  logic [15:0]         product,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [15:0]         out_data,
  output logic [5:0]          out_i,
  output logic [5:0]          out_j,
  output logic                out_last,
  output logic                busy,
`ifdef MULT_SCAN_SUM_EN
  output logic [26:0]         sum_out,
  output logic                sum_valid,
`endif
  output logic                done
);

  localparam int CNT_W = $clog2(LATENCY + 2);
  localparam logic [5:0] ROWS_MAX = 6'(ROWS);
  localparam logic [5:0] COLS_MAX = 6'(COLS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SCAN   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [8*ROWS-1:0]  feature_q, feature_d;
  logic [8*COLS-1:0]  weight_q, weight_d;
  logic [5:0]         rows_q, rows_d;
  logic [5:0]         cols_q, cols_d;
  logic [5:0]         addr_i_q, addr_i_d;
  logic [5:0]         addr_j_q, addr_j_d;
  logic               remaining_q, remaining_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        out_data_q, out_data_d;
  logic [5:0]         out_i_q, out_i_d;
  logic [5:0]         out_j_q, out_j_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef MULT_SCAN_SUM_EN
  logic [26:0]        acc_q, acc_d;
  logic               sum_valid_q, sum_valid_d;
`endif

  logic [5:0] rows_clamped;
  logic [5:0] cols_clamped;
  logic       accept;
  logic       can_capture;
  logic       last_elem;
  logic       col_wrap;

  assign rows_clamped = (n_rows > ROWS_MAX) ? ROWS_MAX : n_rows;
  assign cols_clamped = (n_cols > COLS_MAX) ? COLS_MAX : n_cols;
  assign accept       = out_valid_q && out_ready;
  assign can_capture  = (!out_valid_q || out_ready) && remaining_q;
  assign col_wrap     = (addr_j_q == cols_q - 6'd1);
  assign last_elem    = (addr_i_q == rows_q - 6'd1) && col_wrap;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    feature_d   = feature_q;
    weight_d    = weight_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    addr_i_d    = addr_i_q;
    addr_j_d    = addr_j_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_i_d     = out_i_q;
    out_j_d     = out_j_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef MULT_SCAN_SUM_EN
    acc_d       = acc_q;
    sum_valid_d = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rows_d   = rows_clamped;
          cols_d   = cols_clamped;
          addr_i_d = 6'd0;
          addr_j_d = 6'd0;
          cnt_d    = '0;
          busy_d   = 1'b1;
`ifdef MULT_SCAN_SUM_EN
          acc_d    = 27'd0;
`endif
          // An empty window skips the array entirely and leaves the operands untouched.
          if (rows_clamped == 6'd0 || cols_clamped == 6'd0) begin
            state_d = S_DONE;
          end else begin
            feature_d   = feature_in;
            weight_d    = weight_in;
            remaining_d = 1'b1;
            state_d     = S_SETTLE;
          end
        end
      end

      S_SETTLE: begin
        if (cnt_q == CNT_W'(LATENCY)) begin
          state_d = S_SCAN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_SCAN: begin
`ifdef MULT_SCAN_SUM_EN
        if (accept) begin
          acc_d = acc_q + {{11{out_data_q[15]}}, out_data_q};
        end
`endif
        if (accept && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_DONE;
        end else if (can_capture) begin
          out_data_d  = product;
          out_i_d     = addr_i_q;
          out_j_d     = addr_j_q;
          out_valid_d = 1'b1;
          out_last_d  = last_elem;
          // The address parks on the final element once it has been captured.
          if (last_elem) begin
            remaining_d = 1'b0;
          end else if (col_wrap) begin
            addr_j_d = 6'd0;
            addr_i_d = addr_i_q + 6'd1;
          end else begin
            addr_j_d = addr_j_q + 6'd1;
          end
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
`ifdef MULT_SCAN_SUM_EN
        sum_valid_d = 1'b1;
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      feature_q   <= '0;
      weight_q    <= '0;
      rows_q      <= 6'd0;
      cols_q      <= 6'd0;
      addr_i_q    <= 6'd0;
      addr_j_q    <= 6'd0;
      remaining_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
      out_i_q     <= 6'd0;
      out_j_q     <= 6'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef MULT_SCAN_SUM_EN
      acc_q       <= 27'd0;
      sum_valid_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      feature_q   <= feature_d;
      weight_q    <= weight_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      addr_i_q    <= addr_i_d;
      addr_j_q    <= addr_j_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_i_q     <= out_i_d;
      out_j_q     <= out_j_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef MULT_SCAN_SUM_EN
      acc_q       <= acc_d;
      sum_valid_q <= sum_valid_d;
`endif
    end
  end

  assign feature   = feature_q;
  assign weight    = weight_q;
  assign addr_i    = addr_i_q;
  assign addr_j    = addr_j_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_i     = out_i_q;
  assign out_j     = out_j_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef MULT_SCAN_SUM_EN
  assign sum_out   = acc_q;
  assign sum_valid = sum_valid_q;
`endif

endmodule
